int_mult_pool_arb: RTL

INT_MULT_POOL_ARB -- requirements
Module: int_mult_pool_arb

---
 rtl/int_mult_pool_arb.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/int_mult_pool_arb.sv
// int_mult_pool_arb
// Shared pool of LANES unsigned multipliers time-shared between two clients,
// FFT and NTT. A three-state arbiter grants one client at a time. A burst
// counter forces a hand-over after MAX_BURST consecutive accepts, but only
// while the other client is waiting. Each accept issues all lanes together
// into an LAT-deep pipeline. A valid bit and an owner tag travel with the
// products, so every result is returned to the client that issued it.
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   fft_valid / fft_ready    FFT issue handshake (ready is a decode of the grant state)
//   a_fft, b_fft             FFT operands, LANES x WIDTH
//   ntt_valid / ntt_ready    NTT issue handshake
//   a_ntt, b_ntt             NTT operands, LANES x WIDTH
//   result                   full products, LANES x 2*WIDTH, held between results
//   result_low               low LOW_W bits of each lane of result
//   res_valid_fft/_ntt       one-cycle pulse marking which client owns result
module int_mult_pool_arb #(
   parameter int LANES     = 4,
   parameter int WIDTH     = 54,
   parameter int LOW_W     = 24,
   parameter int LAT       = 4,
   parameter int MAX_BURST = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              fft_valid,
   output logic                              fft_ready,
   input  logic [LANES-1:0][WIDTH-1:0]       a_fft,
   input  logic [LANES-1:0][WIDTH-1:0]       b_fft,
   input  logic                              ntt_valid,
   output logic                              ntt_ready,
   input  logic [LANES-1:0][WIDTH-1:0]       a_ntt,
   input  logic [LANES-1:0][WIDTH-1:0]       b_ntt,
   output logic [LANES-1:0][2*WIDTH-1:0]     result,
   output logic [LANES-1:0][LOW_W-1:0]       result_low,
   output logic                              res_valid_fft,
   output logic                              res_valid_ntt
);

   localparam int PW = 2 * WIDTH;
   localparam int BW = $clog2(MAX_BURST + 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] GNT_FFT = 2'd1;
   localparam logic [1:0] GNT_NTT = 2'd2;

   localparam logic [BW:0]   BURST_LIMIT = (BW + 1)'(MAX_BURST);
   localparam logic [BW-1:0] BURST_SAT   = BW'(MAX_BURST);

   logic [1:0]    state, state_nxt;
   logic          last_owner, last_owner_nxt;
   logic [BW-1:0] burst, burst_nxt;
   logic [BW:0]   burst_inc;
   logic          acc_fft, acc_ntt, hit_max;

   // Both readys decode the registered state, so neither can depend combinationally on a valid.
   assign fft_ready = (state == GNT_FFT);
   assign ntt_ready = (state == GNT_NTT);
   assign acc_fft   = fft_valid & fft_ready;
   assign acc_ntt   = ntt_valid & ntt_ready;

   // hit_max is true when this cycle's accept completes a full burst.
   assign burst_inc = {1'b0, burst} + (BW + 1)'(1);
   assign hit_max   = (acc_fft | acc_ntt) & (burst_inc >= BURST_LIMIT);

   // Arbitration. last_owner = 1 means NTT was served last. From IDLE, a tie goes to the other client.
   // While granted, hand over when the rival waits and the owner has either stopped or used its burst.
   // With no rival waiting, the count saturates instead of forcing a switch.
   always_comb begin
      state_nxt      = state;
      burst_nxt      = burst;
      last_owner_nxt = last_owner;
      if (acc_fft) last_owner_nxt = 1'b0;
      if (acc_ntt) last_owner_nxt = 1'b1;
      case (state)
         IDLE: begin
            burst_nxt = '0;
            if (fft_valid && ntt_valid) state_nxt = last_owner ? GNT_FFT : GNT_NTT;
            else if (fft_valid)         state_nxt = GNT_FFT;
            else if (ntt_valid)         state_nxt = GNT_NTT;
         end
         GNT_FFT: begin
            if (ntt_valid && (!fft_valid || hit_max)) begin
               state_nxt = GNT_NTT;
               burst_nxt = '0;
            end else if (!fft_valid) begin
               state_nxt = IDLE;
               burst_nxt = '0;
            end else if (hit_max) begin
               burst_nxt = BURST_SAT;
            end else begin
               burst_nxt = burst_inc[BW-1:0];
            end
         end
         GNT_NTT: begin
            if (fft_valid && (!ntt_valid || hit_max)) begin
               state_nxt = GNT_FFT;
               burst_nxt = '0;
            end else if (!ntt_valid) begin
               state_nxt = IDLE;
               burst_nxt = '0;
            end else if (hit_max) begin
               burst_nxt = BURST_SAT;
            end else begin
               burst_nxt = burst_inc[BW-1:0];
            end
         end
         default: begin
            state_nxt = IDLE;
            burst_nxt = '0;
         end
      endcase
   end

   // Arbiter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_owner <= 1'b1;
         burst      <= '0;
      end else begin
         state      <= state_nxt;
         last_owner <= last_owner_nxt;
         burst      <= burst_nxt;
      end
   end

   // A single set of multipliers is fed by whichever client holds the grant.
   // This is stage 0: a combinational product formed in the accept cycle.
   logic [LANES-1:0][WIDTH-1:0] op_a, op_b;
   logic [LANES-1:0][PW-1:0]    in_prod;
   logic                        in_vld, in_own;

   assign op_a   = fft_ready ? a_fft : a_ntt;
   assign op_b   = fft_ready ? b_fft : b_ntt;
   assign in_vld = acc_fft | acc_ntt;
   assign in_own = acc_ntt;

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         in_prod[i] = PW'(op_a[i]) * PW'(op_b[i]);
      end
   end

   // LAT-1 internal register stages carry the product, its valid bit and its owner tag.
   // The output register is the final stage, so an accept in cycle T appears in cycle T+LAT.
   logic [LANES-1:0][PW-1:0] tail_prod;
   logic                     tail_vld, tail_own;

   generate
      if (LAT == 1) begin : g_direct
         assign tail_prod = in_prod;
         assign tail_vld  = in_vld;
         assign tail_own  = in_own;
      end else begin : g_pipe
         logic [LANES-1:0][PW-1:0] pipe_prod [1:LAT-1];
         logic [LAT-1:1]           pipe_vld;
         logic [LAT-1:1]           pipe_own;

         // Only the valid and owner bits need resetting: they decide whether a product is ever seen.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               pipe_vld <= '0;
               pipe_own <= '0;
            end else begin
               pipe_vld[1] <= in_vld;
               pipe_own[1] <= in_own;
               for (int k = 2; k < LAT; k++) begin
                  pipe_vld[k] <= pipe_vld[k-1];
                  pipe_own[k] <= pipe_own[k-1];
               end
            end
         end

         // The product registers run freely; bubbles travel with a cleared valid bit.
         always_ff @(posedge clk) begin
            pipe_prod[1] <= in_prod;
            for (int k = 2; k < LAT; k++) begin
               pipe_prod[k] <= pipe_prod[k-1];
            end
         end

         assign tail_prod = pipe_prod[LAT-1];
         assign tail_vld  = pipe_vld[LAT-1];
         assign tail_own  = pipe_own[LAT-1];
      end
   endgenerate

   // The output stage loads only on a valid result, so result holds its value through bubbles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result        <= '0;
         res_valid_fft <= 1'b0;
         res_valid_ntt <= 1'b0;
      end else begin
         res_valid_fft <= tail_vld & ~tail_own;
         res_valid_ntt <= tail_vld & tail_own;
         if (tail_vld) result <= tail_prod;
      end
   end

   // The low slice of each lane follows the held result.
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         result_low[i] = result[i][LOW_W-1:0];
      end
   end

endmodule
